// File: rtl/ahb_master_ctrl_pkg.sv
// Shared AHB encodings and controller state for ahb_master_ctrl.
// Bus widths, transfer/burst/size codes and the FSM state enum.
package Definitions;

    localparam int DEF_DATAWIDTH = 32;
    localparam int DEF_ADDRWIDTH = 32;

    typedef enum logic [1:0] {
        TR_IDLE   = 2'b00,
        TR_BUSY   = 2'b01,
        TR_NONSEQ = 2'b10,
        TR_SEQ    = 2'b11
    } Trans_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_BURST,
        ST_LAST
    } State_t;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;

    // A beat landing on a 1 KB boundary must restart as NONSEQ.
    function automatic Trans_t beat_trans(input logic [9:0] next_lo);
        return (next_lo == 10'd0) ? TR_NONSEQ : TR_SEQ;
    endfunction

endpackage

// File: rtl/ahb_master_ctrl.sv
// AHB-Lite burst master: turns one command into a SINGLE/INCR burst,
// streams write data in, read data out, and aborts on ERROR.
module ahb_master_ctrl
    import Definitions::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int ADDRWIDTH = DEF_ADDRWIDTH
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ADDRWIDTH-1:0] cmd_addr,
    input  logic                 cmd_write,
    input  logic [3:0]           cmd_len,
    input  logic [DATAWIDTH-1:0] wr_data,
    output logic                 wr_data_ack,
    output logic [DATAWIDTH-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 done,
    output logic                 err,
    output logic [ADDRWIDTH-1:0] HADDR,
    output Trans_t               HTRANS,
    output logic                 HWRITE,
    output logic [2:0]           HSIZE,
    output logic [2:0]           HBURST,
    output logic [DATAWIDTH-1:0] HWDATA,
    input  logic [DATAWIDTH-1:0] HRDATA,
    input  logic                 HREADY,
    input  logic                 HRESP
);

    State_t               st_q, st_d;
    Trans_t               htrans_q, htrans_d;
    logic [ADDRWIDTH-1:0] haddr_q, haddr_d, nxt_addr;
    logic                 hwrite_q, hwrite_d;
    logic [2:0]           hburst_q, hburst_d;
    logic [DATAWIDTH-1:0] hwdata_q, hwdata_d;
    logic [DATAWIDTH-1:0] rd_data_q, rd_data_d;
    logic [3:0]           beat_q, beat_d;
    logic [3:0]           len_q, len_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 wr_ack_q, wr_ack_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 dphase, aphase;

    assign dphase   = (st_q == ST_BURST) || (st_q == ST_LAST);
    assign aphase   = (htrans_q == TR_NONSEQ) || (htrans_q == TR_SEQ);
    assign nxt_addr = haddr_q + ADDRWIDTH'(4);

    always_comb begin
        st_d       = st_q;
        htrans_d   = htrans_q;
        haddr_d    = haddr_q;
        hwrite_d   = hwrite_q;
        hburst_d   = hburst_q;
        hwdata_d   = hwdata_q;
        rd_data_d  = rd_data_q;
        beat_d     = beat_q;
        len_d      = len_q;
        rd_valid_d = 1'b0;
        wr_ack_d   = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (st_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    st_d     = ST_ADDR;
                    htrans_d = TR_NONSEQ;
                    haddr_d  = cmd_addr;
                    hwrite_d = cmd_write;
                    hburst_d = (cmd_len == 4'd0) ? HBURST_SINGLE : HBURST_INCR;
                    beat_d   = 4'd0;
                    len_d    = cmd_len;
                end
            end
            default: begin
                // Two-cycle ERROR: cancel the pending beat first, then abort.
                if (dphase && HRESP) begin
                    htrans_d = TR_IDLE;
                    if (HREADY) begin
                        err_d = 1'b1;
                        st_d  = ST_IDLE;
                    end
                end else if (HREADY) begin
                    if (dphase && !hwrite_q) begin
                        rd_data_d  = HRDATA;
                        rd_valid_d = 1'b1;
                    end
                    if (st_q == ST_LAST) begin
                        done_d = 1'b1;
                        st_d   = ST_IDLE;
                    end else if (aphase) begin
                        if (hwrite_q) begin
                            hwdata_d = wr_data;
                            wr_ack_d = 1'b1;
                        end
                        if (beat_q == len_q) begin
                            st_d     = ST_LAST;
                            htrans_d = TR_IDLE;
                        end else begin
                            st_d     = ST_BURST;
                            beat_d   = beat_q + 4'd1;
                            haddr_d  = nxt_addr;
                            htrans_d = beat_trans(nxt_addr[9:0]);
                        end
                    end else begin
                        st_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            st_q       <= ST_IDLE;
            htrans_q   <= TR_IDLE;
            haddr_q    <= '0;
            hwrite_q   <= 1'b0;
            hburst_q   <= HBURST_SINGLE;
            hwdata_q   <= '0;
            rd_data_q  <= '0;
            beat_q     <= 4'd0;
            len_q      <= 4'd0;
            rd_valid_q <= 1'b0;
            wr_ack_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            st_q       <= st_d;
            htrans_q   <= htrans_d;
            haddr_q    <= haddr_d;
            hwrite_q   <= hwrite_d;
            hburst_q   <= hburst_d;
            hwdata_q   <= hwdata_d;
            rd_data_q  <= rd_data_d;
            beat_q     <= beat_d;
            len_q      <= len_d;
            rd_valid_q <= rd_valid_d;
            wr_ack_q   <= wr_ack_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign cmd_ready   = (st_q == ST_IDLE);
    assign HTRANS      = htrans_q;
    assign HADDR       = haddr_q;
    assign HWRITE      = hwrite_q;
    assign HSIZE       = HSIZE_WORD;
    assign HBURST      = hburst_q;
    assign HWDATA      = hwdata_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign wr_data_ack = wr_ack_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_ahb_master_ctrl.sv
// Directed bench for ahb_master_ctrl: hand-computed cycle-by-cycle
// expectations for reads, writes, waits, 1 KB crossing, ERROR and reset.
module tb_ahb_master_ctrl;
    import Definitions::*;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_write;
    logic [3:0]  cmd_len;
    logic [31:0] wr_data;
    logic        wr_data_ack;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        done;
    logic        err;
    logic [31:0] HADDR;
    Trans_t      HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    int errors = 0;
    int checks = 0;
    int ack_cnt;

    ahb_master_ctrl dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_write(cmd_write), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_data_ack(wr_data_ack),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".htrans"}, 64'(HTRANS), 64'(TR_IDLE));
        chk({tag, ".haddr"}, 64'(HADDR), 64'h0);
        chk({tag, ".hwrite"}, 64'(HWRITE), 64'h0);
        chk({tag, ".hsize"}, 64'(HSIZE), 64'h2);
        chk({tag, ".hburst"}, 64'(HBURST), 64'h0);
        chk({tag, ".hwdata"}, 64'(HWDATA), 64'h0);
        chk({tag, ".cmd_ready"}, 64'(cmd_ready), 64'h1);
        chk({tag, ".rd_valid"}, 64'(rd_valid), 64'h0);
        chk({tag, ".rd_data"}, 64'(rd_data), 64'h0);
        chk({tag, ".wr_ack"}, 64'(wr_data_ack), 64'h0);
        chk({tag, ".done"}, 64'(done), 64'h0);
        chk({tag, ".err"}, 64'(err), 64'h0);
    endtask

    task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] l);
        cmd_valid = 1'b1; cmd_addr = a; cmd_write = w; cmd_len = l;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESET = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_len = '0;
        wr_data = '0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
        tick(); tick();
        HRESET = 1'b0;
        chk_reset_vals("reset");

        // single read at 0x100
        issue(32'h100, 1'b0, 4'd0);
        chk("rd1.htrans", 64'(HTRANS), 64'(TR_NONSEQ));
        chk("rd1.haddr", 64'(HADDR), 64'h100);
        chk("rd1.hburst", 64'(HBURST), 64'h0);
        chk("rd1.ready", 64'(cmd_ready), 64'h0);
        HRDATA = 32'hA5A5_0001;
        tick();
        chk("rd1.last_idle", 64'(HTRANS), 64'(TR_IDLE));
        chk("rd1.no_rv_yet", 64'(rd_valid), 64'h0);
        tick();
        chk("rd1.rv", 64'(rd_valid), 64'h1);
        chk("rd1.data", 64'(rd_data), 64'hA5A5_0001);
        chk("rd1.done", 64'(done), 64'h1);
        chk("rd1.ready_after", 64'(cmd_ready), 64'h1);
        tick();
        chk("rd1.rv_pulse", 64'(rd_valid), 64'h0);
        chk("rd1.done_pulse", 64'(done), 64'h0);

        // 4-beat write at 0x200, no waits
        issue(32'h200, 1'b1, 4'd3);
        chk("wr4.hburst", 64'(HBURST), 64'h1);
        chk("wr4.hwrite", 64'(HWRITE), 64'h1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("wr4.haddr%0d", k), 64'(HADDR), 64'(32'h200 + 4 * k));
            chk($sformatf("wr4.htrans%0d", k), 64'(HTRANS), (k == 0) ? 64'(TR_NONSEQ) : 64'(TR_SEQ));
            chk($sformatf("wr4.ack%0d", k), 64'(wr_data_ack), (k == 0) ? 64'h0 : 64'h1);
            if (k > 0) chk($sformatf("wr4.hwdata%0d", k), 64'(HWDATA), 64'(32'hD0 + k - 1));
            wr_data = 32'hD0 + k;
            tick();
        end
        chk("wr4.last_idle", 64'(HTRANS), 64'(TR_IDLE));
        chk("wr4.ack3", 64'(wr_data_ack), 64'h1);
        chk("wr4.hwdata3", 64'(HWDATA), 64'hD3);
        tick();
        chk("wr4.done", 64'(done), 64'h1);
        chk("wr4.ack_off", 64'(wr_data_ack), 64'h0);
        tick();

        // 4-beat read at 0x300, two wait states on beat 2
        issue(32'h300, 1'b0, 4'd3);
        chk("rdw.c0.haddr", 64'(HADDR), 64'h300);
        tick();
        chk("rdw.c1.haddr", 64'(HADDR), 64'h304);
        chk("rdw.c1.htrans", 64'(HTRANS), 64'(TR_SEQ));
        HRDATA = 32'hB000_0000;
        tick();
        chk("rdw.c2.rv", 64'(rd_valid), 64'h1);
        chk("rdw.c2.data", 64'(rd_data), 64'hB000_0000);
        HRDATA = 32'hB000_0001;
        tick();
        chk("rdw.c3.data", 64'(rd_data), 64'hB000_0001);
        chk("rdw.c3.haddr", 64'(HADDR), 64'h30C);
        HREADY = 1'b0; HRDATA = 32'hDEAD_BEEF;
        tick();
        chk("rdw.w1.haddr", 64'(HADDR), 64'h30C);
        chk("rdw.w1.htrans", 64'(HTRANS), 64'(TR_SEQ));
        chk("rdw.w1.rv", 64'(rd_valid), 64'h0);
        tick();
        chk("rdw.w2.haddr", 64'(HADDR), 64'h30C);
        chk("rdw.w2.htrans", 64'(HTRANS), 64'(TR_SEQ));
        chk("rdw.w2.rv", 64'(rd_valid), 64'h0);
        HREADY = 1'b1; HRDATA = 32'hB000_0002;
        tick();
        chk("rdw.c6.rv", 64'(rd_valid), 64'h1);
        chk("rdw.c6.data", 64'(rd_data), 64'hB000_0002);
        chk("rdw.c6.htrans", 64'(HTRANS), 64'(TR_IDLE));
        HRDATA = 32'hB000_0003;
        tick();
        chk("rdw.c7.data", 64'(rd_data), 64'hB000_0003);
        chk("rdw.c7.done", 64'(done), 64'h1);
        tick();

        // 3-beat read across the 1 KB boundary
        issue(32'h3FC, 1'b0, 4'd2);
        chk("kb.b0.haddr", 64'(HADDR), 64'h3FC);
        chk("kb.b0.htrans", 64'(HTRANS), 64'(TR_NONSEQ));
        tick();
        chk("kb.b1.haddr", 64'(HADDR), 64'h400);
        chk("kb.b1.htrans", 64'(HTRANS), 64'(TR_NONSEQ));
        tick();
        chk("kb.b2.haddr", 64'(HADDR), 64'h404);
        chk("kb.b2.htrans", 64'(HTRANS), 64'(TR_SEQ));
        tick();
        chk("kb.last", 64'(HTRANS), 64'(TR_IDLE));
        tick();
        chk("kb.done", 64'(done), 64'h1);
        tick();

        // 8-beat write at 0x500, ERROR on the third data phase
        ack_cnt = 0;
        issue(32'h500, 1'b1, 4'd7);
        for (int k = 0; k < 3; k++) begin
            wr_data = 32'hE0 + k;
            tick();
            if (wr_data_ack) ack_cnt++;
        end
        chk("er.haddr", 64'(HADDR), 64'h50C);
        HRESP = 1'b1; HREADY = 1'b0;
        tick();
        chk("er.c1.htrans", 64'(HTRANS), 64'(TR_IDLE));
        chk("er.c1.ack", 64'(wr_data_ack), 64'h0);
        chk("er.c1.err", 64'(err), 64'h0);
        HREADY = 1'b1;
        tick();
        HRESP = 1'b0;
        chk("er.err", 64'(err), 64'h1);
        chk("er.no_done", 64'(done), 64'h0);
        chk("er.no_ack", 64'(wr_data_ack), 64'h0);
        chk("er.ready", 64'(cmd_ready), 64'h1);
        chk("er.ack_total", 64'(ack_cnt), 64'h3);
        tick();
        chk("er.err_pulse", 64'(err), 64'h0);
        chk("er.htrans_idle", 64'(HTRANS), 64'(TR_IDLE));

        // reset in the middle of a 16-beat read
        issue(32'h600, 1'b0, 4'd15);
        HRDATA = 32'h1234_5678;
        tick(); tick(); tick();
        chk("rst.mid_rv", 64'(rd_valid), 64'h1);
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        chk_reset_vals("rst");
        issue(32'h40, 1'b1, 4'd0);
        chk("post.htrans", 64'(HTRANS), 64'(TR_NONSEQ));
        chk("post.haddr", 64'(HADDR), 64'h40);
        chk("post.hwrite", 64'(HWRITE), 64'h1);
        wr_data = 32'hCAFE_F00D;
        tick();
        chk("post.ack", 64'(wr_data_ack), 64'h1);
        chk("post.hwdata", 64'(HWDATA), 64'hCAFE_F00D);
        tick();
        chk("post.done", 64'(done), 64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb_master_ctrl.md
AHB_MASTER_CTRL -- requirements
Module: ahb_master_ctrl

Interface
REQ-001 Parameter DATAWIDTH, 32, data bus width; taken from package Definitions.
REQ-002 Parameter ADDRWIDTH, 32, address bus width; taken from package Definitions.
REQ-003 HCLK  input  1  sole clock; all state changes on rising edge.
REQ-004 HRESET  input  1  reset, synchronous and active-high.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  controller can accept a command.
REQ-007 cmd_addr  input  ADDRWIDTH  start byte address, word aligned.
REQ-008 cmd_write  input  1  1 = write burst, 0 = read burst.
REQ-009 cmd_len  input  4  beats minus one (0 = single, 15 = 16 beats).
REQ-010 wr_data  input  DATAWIDTH  write data for the current beat.
REQ-011 wr_data_ack  output  1  one-cycle pulse: wr_data consumed this edge.
REQ-012 rd_data  output  DATAWIDTH  read data of the completed beat.
REQ-013 rd_valid  output  1  one-cycle pulse: rd_data valid.
REQ-014 done  output  1  one-cycle pulse: final beat data phase completed (OKAY).
REQ-015 err  output  1  one-cycle pulse: burst aborted on ERROR response.
REQ-016 HADDR  output  ADDRWIDTH; HTRANS  output  2 (Trans_t); HWRITE  output  1; HSIZE  output  3; HBURST  output  3; HWDATA  output  DATAWIDTH.
REQ-017 HRDATA  input  DATAWIDTH; HREADY  input  1; HRESP  input  1 (0 = OKAY, 1 = ERROR).

Function
REQ-018 FSM states: ST_IDLE, ST_ADDR (first NONSEQ), ST_BURST (SEQ beats), ST_LAST (final data phase, HTRANS=IDLE).
REQ-019 cmd_ready = 1 only in ST_IDLE; a command is accepted on an edge with cmd_valid && cmd_ready.
REQ-020 Accept at edge T -> from T+1: HTRANS=NONSEQ, HADDR=cmd_addr, HWRITE=cmd_write, HSIZE=3'b010, HBURST=SINGLE (3'b000) when cmd_len=0, else INCR (3'b001).
REQ-021 Address phase completes on an edge with HREADY=1 and HTRANS in {NONSEQ, SEQ}. While HREADY=0, all address/control outputs hold.
REQ-022 After each completed non-final address phase: next beat HTRANS=SEQ, HADDR += 4.
REQ-023 When HADDR+4 crosses a 1 KB boundary (bits [9:0] wrap to 0), that beat uses NONSEQ instead of SEQ.
REQ-024 After the final address phase completes -> ST_LAST, HTRANS=IDLE.
REQ-025 Write: at each address-phase completion, wr_data registers into HWDATA and wr_data_ack pulses; HWDATA holds until its data phase completes.
REQ-026 Read: at each data-phase completion (HREADY=1, OKAY), rd_data = HRDATA and rd_valid pulses the following cycle.
REQ-027 Final data phase completes OKAY -> done pulses, return to ST_IDLE; cmd_ready is 1 in the next cycle. No back-to-back pipelining of commands.
REQ-028 ERROR, first cycle (HRESP=1, HREADY=0): drive HTRANS=IDLE immediately (cancel pending beat).
REQ-029 ERROR, second cycle (HRESP=1, HREADY=1): err pulses; remaining beats are dropped; no rd_valid or wr_data_ack for the failed or cancelled beats; return to ST_IDLE.
REQ-030 An internal beat counter counts address phases issued; it never exceeds cmd_len.

Reset
REQ-031 HRESET=1 at an edge forces ST_IDLE: HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=3'b010, HBURST=0, HWDATA=0, cmd_ready=1, rd_valid=0, rd_data=0, wr_data_ack=0, done=0, err=0.
REQ-032 Reset mid-burst aborts immediately; no done or err pulse is generated.

Structure
REQ-033 Trans_t, the HBURST/HSIZE encodings and the FSM state enum live in package Definitions; the module imports them.
REQ-034 Single flat module; no sub-module.

Verification
REQ-035 Single read, cmd_addr=0x100, HREADY=1 always -> NONSEQ@0x100 for 1 cycle, rd_valid once with HRDATA, done pulse.
REQ-036 4-beat write at 0x200, 0 waits -> HTRANS NONSEQ,SEQ,SEQ,SEQ at 0x200/204/208/20C; 4 wr_data_ack; HWDATA lags HADDR by one cycle.
REQ-037 4-beat read with HREADY=0 for 2 cycles on beat 2 -> HADDR/HTRANS stable during wait; 4 rd_valid in order.
REQ-038 3-beat read at 0x3FC -> beats 0x3FC NONSEQ, 0x400 NONSEQ, 0x404 SEQ.
REQ-039 8-beat write, ERROR on beat 3 -> HTRANS=IDLE in first error cycle, err pulse, 3 wr_data_ack total or fewer, no done, cmd_ready=1 afterwards.
REQ-040 HRESET asserted mid 16-beat read -> next cycle all outputs at reset values; a new command then runs normally.
